accumulator_signed_param: RTL and testbench

Streaming signed accumulator that sums a fixed-length frame of `ACC_LEN` two's-complement samples and emits one width-reduced result per frame. It is the additive counterpart to the signed subtractor stage in the in-memory datapath. It sits between sample producers and result consumers, with a valid/ready handshake on both sides. Width handling uses the same MSB/LSB slice selection as the rest of the signed arithmetic submodules.

---
 rtl/accumulator_signed_param.sv | 136 +++++++++++++
 tb/tb_accumulator_signed_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_signed_param.sv
// rtl/accumulator_signed_param.sv - streaming signed frame accumulator with width-reduced result
//
// Sums ACC_LEN two's-complement samples per frame and emits one
// DATA_OUT_WIDTH result per frame through a valid/ready handshake.
//
// Optional feature macro: ACCUM_SATURATE_EN
//   defined   : with TAKE_MSB=0 the LSB slice clamps to the signed output range
//   undefined : the LSB slice wraps (plain truncation)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   data_in carries a sample
//   in_ready   block accepts a sample this cycle (registered)
//   data_in    signed sample, DATA_IN_WIDTH bits
//   flush      abort the current frame (ignored while a result is pending)
//   out_valid  data_out holds a frame result (registered)
//   out_ready  consumer takes the result
//   data_out   signed result, DATA_OUT_WIDTH bits (registered)
module accumulator_signed_param #(
  parameter int DATA_IN_WIDTH  = 8,
  parameter int DATA_OUT_WIDTH = 8,
  parameter int ACC_LEN        = 16,
  parameter int ACC_WIDTH      = DATA_IN_WIDTH + $clog2(ACC_LEN),
  parameter bit TAKE_MSB       = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [DATA_IN_WIDTH-1:0]  data_in,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [DATA_OUT_WIDTH-1:0] data_out
);

  localparam int CNT_W = $clog2(ACC_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ACC_LEN - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t                      state;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] sum;
  logic [CNT_W-1:0]            count;
  logic [DATA_OUT_WIDTH-1:0]   slice;
  logic                        accept;

  // Sign extension comes from the signed cast of data_in.
  always_comb begin
    sum = acc + ACC_WIDTH'(data_in);
  end

  assign accept = in_valid && in_ready;

`ifdef ACCUM_SATURATE_EN
  localparam logic [DATA_OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_OUT_WIDTH-1){1'b1}}};
  localparam logic [DATA_OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_OUT_WIDTH-1){1'b0}}};

  // The sum fits the output range exactly when every bit from the output
  // sign bit upward is a copy of the accumulator sign bit.
  logic [ACC_WIDTH-DATA_OUT_WIDTH:0] upper;
  logic                              fits;

  always_comb begin
    upper = sum[ACC_WIDTH-1:DATA_OUT_WIDTH-1];
    fits  = (&upper) || !(|upper);
    if (TAKE_MSB) begin
      slice = sum[ACC_WIDTH-1 -: DATA_OUT_WIDTH];
    end else if (fits) begin
      slice = sum[0 +: DATA_OUT_WIDTH];
    end else begin
      slice = sum[ACC_WIDTH-1] ? OUT_MIN : OUT_MAX;
    end
  end
`else
  always_comb begin
    if (TAKE_MSB) begin
      slice = sum[ACC_WIDTH-1 -: DATA_OUT_WIDTH];
    end else begin
      slice = sum[0 +: DATA_OUT_WIDTH];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (flush) begin
            // A sample arriving alongside flush is dropped with the frame.
            acc   <= '0;
            count <= '0;
          end else if (accept) begin
            if (count == LAST_IDX) begin
              data_out  <= slice;
              acc       <= '0;
              count     <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              acc   <= sum;
              count <= count + 1'b1;
            end
          end
        end
        DONE: begin
          // Result is held until taken; flush cannot discard it.
          if (out_ready) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: begin
          state     <= ACCUM;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accumulator_signed_param.sv
// tb/tb_accumulator_signed_param.sv - directed self-checking bench for accumulator_signed_param
module tb_accumulator_signed_param;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] data_in;
  logic       flush;
  logic       out_ready;

  logic       in_ready;
  logic       out_valid;
  logic [7:0] data_out;

  logic       msb_in_ready;
  logic       msb_out_valid;
  logic [7:0] msb_data_out;

  int checks;
  int failures;

  accumulator_signed_param #(
    .DATA_IN_WIDTH (8),
    .DATA_OUT_WIDTH(8),
    .ACC_LEN       (4),
    .TAKE_MSB      (1'b0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out)
  );

  accumulator_signed_param #(
    .DATA_IN_WIDTH (8),
    .DATA_OUT_WIDTH(8),
    .ACC_LEN       (4),
    .TAKE_MSB      (1'b1)
  ) dut_msb (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (msb_in_ready),
    .data_in  (data_in),
    .flush    (flush),
    .out_valid(msb_out_valid),
    .out_ready(out_ready),
    .data_out (msb_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int v);
    in_valid = 1'b1;
    data_in  = v[7:0];
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    data_in   = 8'h00;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset hold and release
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 0);

    // 1,2,3,4 back-to-back -> 10
    feed(1);
    feed(2);
    feed(3);
    check("f1_no_early_valid", out_valid, 0);
    feed(4);
    check("f1_out_valid", out_valid, 1);
    check("f1_data_out", data_out, 8'd10);
    check("f1_in_ready_low", in_ready, 0);
    check("f1_msb_data_out", msb_data_out, 8'd2);
    check("f1_msb_out_valid", msb_out_valid, 1);
    tick();
    check("f1_in_ready_back", in_ready, 1);
    check("f1_out_valid_fall", out_valid, 0);

    // 5,-3, bubbles, 7,-20 -> -11
    feed(5);
    feed(-3);
    tick();
    tick();
    tick();
    feed(7);
    check("f2_bubbles_no_count", out_valid, 0);
    feed(-20);
    check("f2_out_valid", out_valid, 1);
    check("f2_data_out", data_out, 8'hF5);
    tick();

    // Backpressure: 10,20,30,40 -> 100 held while out_ready=0
    out_ready = 1'b0;
    feed(10);
    feed(20);
    feed(30);
    feed(40);
    in_valid = 1'b1;
    data_in  = 8'd99;
    flush    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_data_hold", data_out, 8'd100);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    feed(1);
    feed(1);
    feed(1);
    feed(1);
    check("bp_next_frame", data_out, 8'd4);
    tick();

    // -128 x4 -> -512
    for (int i = 0; i < 4; i++) feed(-128);
`ifdef ACCUM_SATURATE_EN
    check("neg_lsb_slice", data_out, 8'h80);
`else
    check("neg_lsb_slice", data_out, 8'h00);
`endif
    check("neg_msb_slice", msb_data_out, 8'h80);
    tick();

    // 127 x4 -> 508
    for (int i = 0; i < 4; i++) feed(127);
`ifdef ACCUM_SATURATE_EN
    check("pos_lsb_slice", data_out, 8'h7F);
`else
    check("pos_lsb_slice", data_out, 8'hFC);
`endif
    check("pos_msb_slice", msb_data_out, 8'h7F);
    tick();

    // Flush mid-frame, sample with flush is discarded
    feed(1);
    feed(2);
    flush    = 1'b1;
    in_valid = 1'b1;
    data_in  = 8'd50;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_no_output", out_valid, 0);
    feed(4);
    feed(4);
    feed(4);
    check("fl_count_cleared", out_valid, 0);
    feed(4);
    check("fl_out_valid", out_valid, 1);
    check("fl_data_out", data_out, 8'd16);
    tick();

    // Reset mid-frame
    feed(1);
    feed(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rm_no_output", out_valid, 0);
    feed(4);
    feed(4);
    feed(4);
    check("rm_count_cleared", out_valid, 0);
    feed(4);
    check("rm_out_valid", out_valid, 1);
    check("rm_data_out", data_out, 8'd16);

    // Reset while a result is pending
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rd_out_valid", out_valid, 0);
    check("rd_in_ready", in_ready, 1);
    check("rd_data_out", data_out, 0);
    out_ready = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
